// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the program-run sequencer.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      START,
      RUN,
      REPORT,
      NEXT
   } run_state_t;

   localparam int unsigned NPROG_DEF   = 3;
   localparam int unsigned CW_DEF      = 16;
   localparam int unsigned TIMEOUT_DEF = 32'h0000_FFFF;
   localparam int unsigned RSTCYC_DEF  = 2;

   // Index width that stays legal (>=1) for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_ctrl_timer.sv
// Run-length counter: clears in START, counts RUN cycles, flags the timeout limit.
module run_timer
   import run_ctrl_pkg::*;
#(
   parameter int unsigned CW      = CW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic [CW-1:0] o_cnt_inc_c,
   output logic          o_at_limit_c
);

   logic [CW-1:0] r_cnt;

   // Stops at the limit so the count can never wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_at_limit_c) begin
         r_cnt <= o_cnt_inc_c;
      end
   end

   assign o_cnt        = r_cnt;
   assign o_cnt_inc_c  = r_cnt + CW'(1);
   assign o_at_limit_c = (o_cnt_inc_c == CW'(TIMEOUT));

endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: resets, starts and times each program 0..NPROG-1 in turn.
// Optional RUN_CTRL_TOTAL_EN adds a saturating TotalCnt of all run lengths in a sequence.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned NPROG   = NPROG_DEF,
   parameter int unsigned CW      = CW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned RSTCYC  = RSTCYC_DEF,
   localparam int unsigned PW     = idx_w(NPROG)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Go,
   input  logic          CoreAck,
   output logic          CoreReset,
   output logic          CoreStart,
   output logic [PW-1:0] ProgSel,
   output logic          Busy,
   output logic          CntValid,
   output logic [CW-1:0] CycleCnt,
   output logic [PW-1:0] ProgIdx,
   output logic          TimedOut,
   output logic          Done
`ifdef RUN_CTRL_TOTAL_EN
   ,
   output logic [CW+3:0] TotalCnt
`endif
);

   localparam int unsigned   RW    = idx_w(RSTCYC);
   localparam logic [PW-1:0] LAST  = PW'(NPROG - 1);
   localparam logic [RW-1:0] RLAST = RW'(RSTCYC - 1);

   run_state_t    r_state;
   logic [RW-1:0] r_rcnt;
   logic          r_core_reset;
   logic          r_core_start;
   logic [PW-1:0] r_prog_sel;
   logic          r_busy;
   logic          r_cnt_valid;
   logic [CW-1:0] r_cycle_cnt;
   logic [PW-1:0] r_prog_idx;
   logic          r_timed_out;
   logic          r_done;

   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_at_limit;
   logic          w_clr;
   logic          w_en;
   logic          w_ack;
   logic          w_end;

   assign w_clr = (r_state == START);
   assign w_en  = (r_state == RUN);

   run_timer #(
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk        (Clk),
      .i_rst_n      (Reset),
      .i_clr        (w_clr),
      .i_en         (w_en),
      .o_cnt        (w_cnt),
      .o_cnt_inc_c  (w_cnt_inc),
      .o_at_limit_c (w_at_limit)
   );

   // A zero count marks the first RUN cycle, where a stale halt may still be showing.
   assign w_ack = CoreAck && (w_cnt != '0);
   assign w_end = w_ack || w_at_limit;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= IDLE;
         r_rcnt       <= '0;
         r_core_reset <= 1'b1;
         r_core_start <= 1'b0;
         r_prog_sel   <= '0;
         r_busy       <= 1'b0;
         r_cnt_valid  <= 1'b0;
         r_cycle_cnt  <= '0;
         r_prog_idx   <= '0;
         r_timed_out  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_core_start <= 1'b0;
         r_cnt_valid  <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (Go) begin
                  r_state     <= HOLD;
                  r_prog_sel  <= '0;
                  r_timed_out <= 1'b0;
                  r_busy      <= 1'b1;
                  r_rcnt      <= '0;
               end
            end
            HOLD: begin
               if (r_rcnt == RLAST) begin
                  r_state      <= START;
                  r_core_reset <= 1'b0;
                  r_core_start <= 1'b1;
               end else begin
                  r_rcnt <= r_rcnt + RW'(1);
               end
            end
            START: begin
               r_state <= RUN;
            end
            RUN: begin
               // Ack wins over a timeout that lands on the same cycle.
               if (w_end) begin
                  r_state      <= REPORT;
                  r_core_reset <= 1'b1;
                  r_cnt_valid  <= 1'b1;
                  r_cycle_cnt  <= w_cnt_inc;
                  r_prog_idx   <= r_prog_sel;
                  if (!w_ack) begin
                     r_timed_out <= 1'b1;
                  end
               end
            end
            REPORT: begin
               r_state <= NEXT;
               r_done  <= (r_prog_sel == LAST);
            end
            NEXT: begin
               if (r_prog_sel == LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state    <= HOLD;
                  r_prog_sel <= r_prog_sel + PW'(1);
                  r_rcnt     <= '0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_busy       <= 1'b0;
               r_core_reset <= 1'b1;
            end
         endcase
      end
   end

`ifdef RUN_CTRL_TOTAL_EN
   localparam int unsigned TW  = CW + 4;
   localparam int unsigned TW1 = TW + 1;

   logic [TW-1:0] r_total;
   logic [TW:0]   w_sum;

   assign w_sum = {1'b0, r_total} + TW1'(w_cnt_inc);

   // Accumulates each reported run length, pinned at all-ones on overflow.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_total <= '0;
      end else if ((r_state == IDLE) && Go) begin
         r_total <= '0;
      end else if ((r_state == RUN) && w_end) begin
         r_total <= w_sum[TW] ? '1 : w_sum[TW-1:0];
      end
   end

   assign TotalCnt = r_total;
`endif

   assign CoreReset = r_core_reset;
   assign CoreStart = r_core_start;
   assign ProgSel   = r_prog_sel;
   assign Busy      = r_busy;
   assign CntValid  = r_cnt_valid;
   assign CycleCnt  = r_cycle_cnt;
   assign ProgIdx   = r_prog_idx;
   assign TimedOut  = r_timed_out;
   assign Done      = r_done;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl with a behavioural core model and per-sequence reference.
module tb_run_ctrl;

   localparam int NP  = 3;
   localparam int CWB = 16;
   localparam int TO  = 32;
   localparam int RC  = 2;

   logic           Clk;
   logic           Reset;
   logic           Go;
   logic           CoreAck;
   logic           CoreReset;
   logic           CoreStart;
   logic [1:0]     ProgSel;
   logic           Busy;
   logic           CntValid;
   logic [CWB-1:0] CycleCnt;
   logic [1:0]     ProgIdx;
   logic           TimedOut;
   logic           Done;
`ifdef RUN_CTRL_TOTAL_EN
   logic [CWB+3:0] TotalCnt;
   longint         tot_obs;
`endif

   run_ctrl #(
      .NPROG   (NP),
      .CW      (CWB),
      .TIMEOUT (TO),
      .RSTCYC  (RC)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Go        (Go),
      .CoreAck   (CoreAck),
      .CoreReset (CoreReset),
      .CoreStart (CoreStart),
      .ProgSel   (ProgSel),
      .Busy      (Busy),
      .CntValid  (CntValid),
      .CycleCnt  (CycleCnt),
      .ProgIdx   (ProgIdx),
      .TimedOut  (TimedOut),
      .Done      (Done)
`ifdef RUN_CTRL_TOTAL_EN
      ,
      .TotalCnt  (TotalCnt)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int   checks;
   int   failures;
   int   tcount;
   int   q_idx[$];
   int   q_cnt[$];
   int   q_t[$];
   int   done_n;
   int   done_t;
   int   start_n;
   int   start_bad;
   bit   running;
   bit   halted;
   bit   prev_start;
   int   core_cyc;
   int   cur;
   logic [1:0] rst_hist;
   int   ack_at[NP];
   bit   stale[NP];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs after the edge, advance the core model, drive CoreAck.
   task automatic cyc();
      bit ack;
      @(posedge Clk);
      #1;
      tcount++;
      if (CntValid === 1'b1) begin
         q_idx.push_back(int'(ProgIdx));
         q_cnt.push_back(int'(CycleCnt));
         q_t.push_back(tcount);
      end
      if (Done === 1'b1) begin
         done_n++;
         done_t = tcount;
`ifdef RUN_CTRL_TOTAL_EN
         tot_obs = longint'(TotalCnt);
`endif
      end
      if (CoreStart === 1'b1) begin
         start_n++;
         if (rst_hist !== 2'b11 || CoreReset !== 1'b0 || prev_start) start_bad++;
         core_cyc = 0;
         running  = 1'b1;
         halted   = 1'b0;
         cur      = int'(ProgSel);
      end else if (running) begin
         core_cyc++;
      end
      if (CoreReset === 1'b1 || Reset === 1'b0) begin
         running = 1'b0;
         halted  = 1'b0;
      end
      prev_start = (CoreStart === 1'b1);
      rst_hist   = {rst_hist[0], CoreReset};
      ack = 1'b0;
      if (running) begin
         if (ack_at[cur] != 0 && core_cyc == ack_at[cur]) halted = 1'b1;
         ack = halted || (core_cyc == 1 && stale[cur]);
      end
      CoreAck = ack;
   endtask

   // Runs one full Go sequence and checks strobes, timing and flags against the reference.
   task automatic run_seq(input string nm, input bit go_run, input bit go_done);
      int     n[NP];
      int     rep_t[NP];
      int     base;
      bit     to_any;
      longint tot;
      int     guard;
      bit     go_sent;
      base    = 0;
      to_any  = 1'b0;
      tot     = 0;
      go_sent = 1'b0;
      for (int k = 0; k < NP; k++) begin
         if (ack_at[k] >= 1 && ack_at[k] <= TO) begin
            n[k] = (ack_at[k] < 2) ? 2 : ack_at[k];
         end else begin
            n[k]   = TO;
            to_any = 1'b1;
         end
         rep_t[k] = base + RC + 2 + n[k];
         base     = base + RC + 3 + n[k];
         tot      = tot + n[k];
      end
      if (tot > (64'd1 << (CWB + 4)) - 1) tot = (64'd1 << (CWB + 4)) - 1;
      q_idx.delete();
      q_cnt.delete();
      q_t.delete();
      done_n    = 0;
      done_t    = -1;
      start_n   = 0;
      start_bad = 0;
      tcount    = 0;
      Go = 1'b1;
      cyc();
      Go = 1'b0;
      chk({nm, "_go_busy"}, Busy, 1);
      chk({nm, "_go_to_clr"}, TimedOut, 0);
      guard = 0;
      while (done_n == 0 && guard < base + 20) begin
         Go = go_run && !go_sent && running && core_cyc == 3;
         if (Go) go_sent = 1'b1;
         cyc();
         guard++;
      end
      Go = go_done;
      cyc();
      Go = 1'b0;
      chk({nm, "_idle_busy"}, Busy, 0);
      chk({nm, "_done_once"}, done_n, 1);
      chk({nm, "_done_time"}, done_t, base);
      chk({nm, "_starts"}, start_n, NP);
      chk({nm, "_start_shape"}, start_bad, 0);
      chk({nm, "_nvalid"}, q_cnt.size(), NP);
      for (int k = 0; k < NP; k++) begin
         chk({nm, "_idx"}, (k < q_idx.size()) ? q_idx[k] : -1, k);
         chk({nm, "_cnt"}, (k < q_cnt.size()) ? q_cnt[k] : -1, n[k]);
         chk({nm, "_vtime"}, (k < q_t.size()) ? q_t[k] : -1, rep_t[k]);
      end
      chk({nm, "_timedout"}, TimedOut, to_any);
`ifdef RUN_CTRL_TOTAL_EN
      chk({nm, "_total"}, tot_obs, tot);
`endif
   endtask

   initial begin
      int guard;
      int nv;
      int nd;
      checks     = 0;
      failures   = 0;
      tcount     = 0;
      Go         = 1'b0;
      CoreAck    = 1'b0;
      Reset      = 1'b0;
      running    = 1'b0;
      halted     = 1'b0;
      prev_start = 1'b0;
      core_cyc   = 0;
      cur        = 0;
      rst_hist   = 2'b00;
      done_n     = 0;
      done_t     = -1;
      ack_at     = '{0, 0, 0};
      stale      = '{0, 0, 0};

      repeat (3) @(posedge Clk);
      #1;
      chk("rst_core_reset", CoreReset, 1);
      chk("rst_core_start", CoreStart, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_progsel", ProgSel, 0);
      chk("rst_cntvalid", CntValid, 0);
      chk("rst_cyclecnt", CycleCnt, 0);
      chk("rst_progidx", ProgIdx, 0);
      chk("rst_timedout", TimedOut, 0);
      chk("rst_done", Done, 0);
`ifdef RUN_CTRL_TOTAL_EN
      chk("rst_total", TotalCnt, 0);
`endif
      Reset = 1'b1;
      cyc();
      cyc();
      chk("idle_busy", Busy, 0);
      chk("idle_core_reset", CoreReset, 1);

      ack_at = '{10, 25, 7};
      run_seq("basic", 1'b0, 1'b0);

      ack_at = '{5, 5, 5};
      stale  = '{1, 1, 1};
      run_seq("stale", 1'b0, 1'b0);
      stale  = '{0, 0, 0};

      ack_at = '{10, 0, 7};
      run_seq("tmo", 1'b1, 1'b1);
      chk("tmo_sticky", TimedOut, 1);

      ack_at = '{TO, TO + 1, 1};
      run_seq("bound", 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < NP; k++) begin
            ack_at[k] = int'($urandom_range(0, TO + 3));
            stale[k]  = 1'($urandom_range(0, 1));
         end
         run_seq("rand", 1'b0, 1'($urandom_range(0, 1)));
      end
      stale = '{0, 0, 0};

      ack_at = '{10, 25, 7};
      q_idx.delete();
      q_cnt.delete();
      q_t.delete();
      done_n = 0;
      Go = 1'b1;
      cyc();
      Go = 1'b0;
      guard = 0;
      while (!(running && cur == 1 && core_cyc == 4) && guard < 200) begin
         cyc();
         guard++;
      end
      chk("mid_reach_run1", guard < 200, 1);
      nv = q_cnt.size();
      nd = done_n;
      #2;
      Reset = 1'b0;
      #1;
      chk("mid_core_reset", CoreReset, 1);
      chk("mid_busy", Busy, 0);
      chk("mid_cntvalid", CntValid, 0);
      chk("mid_done", Done, 0);
      chk("mid_progsel", ProgSel, 0);
      chk("mid_cyclecnt", CycleCnt, 0);
      cyc();
      cyc();
      chk("mid_no_strobe", (q_cnt.size() - nv) + (done_n - nd), 0);
      Reset = 1'b1;
      cyc();
      chk("mid_rel_busy", Busy, 0);
      chk("mid_rel_core_reset", CoreReset, 1);
      run_seq("after_rst", 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
